// File: rtl/bram_bus_port.sv
// bram_bus_port: valid/ready request port in front of a block RAM with 1-cycle read latency.
// Responses are returned in order through a 2-entry FIFO with a fixed 2-cycle latency.
// Optional macro BRAM_BUS_PORT_ALIGN_CHECK_EN: requests whose byte address is not word
// aligned are rejected (no RAM write, resp_err=1, resp_rdata=0).
module bram_bus_port #(
  parameter int  abits  = 8,
  parameter int  dbytes = 4,
  parameter int  blen   = 8,
  localparam int dbits  = dbytes * blen,
  localparam int obits  = (dbytes > 1) ? $clog2(dbytes) : 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [abits+obits-1:0] req_addr,
  input  logic [dbytes-1:0]      req_we,
  input  logic [dbits-1:0]       req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [dbits-1:0]       resp_rdata,
  output logic                   resp_err,
  output logic [dbytes-1:0]      ram_we,
  output logic [abits-1:0]       ram_addr,
  output logic [dbits-1:0]       ram_wdata,
  input  logic [dbits-1:0]       ram_rdata
);

  // Selects the byte-offset bits of the address; all-zero when a word is a single byte.
  localparam logic [abits+obits-1:0] LOW_MASK = (abits+obits)'((64'd1 << obits) - 64'd1);

  logic             accept;
  logic             pop;
  logic             push;
  logic             misaligned;
  logic [2:0]       owed;
  logic             head_err;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_read_q,  s1_read_d;
  logic             s1_err_q,   s1_err_d;
  logic [1:0]       cnt_q,      cnt_d;
  logic             wr_ptr_q,   wr_ptr_d;
  logic             rd_ptr_q,   rd_ptr_d;

  logic [dbits-1:0] fifo_data_q [2];
  logic             fifo_err_q  [2];
  logic [dbits-1:0] fifo_data_d;
  logic             fifo_err_d;

`ifdef BRAM_BUS_PORT_ALIGN_CHECK_EN
  assign misaligned = (obits > 0) && ((req_addr & LOW_MASK) != '0);
  assign resp_err   = resp_valid & head_err;
`else
  // Low address bits and the stored error flag have no function without the alignment check.
  logic unused_align_bits;
  assign misaligned        = 1'b0;
  assign resp_err          = 1'b0;
  assign unused_align_bits = head_err ^ (^(req_addr & LOW_MASK));
`endif

  // Handshakes. The entry in flight plus the buffered ones must leave room for one more.
  assign pop        = resp_valid & resp_ready;
  assign push       = s1_valid_q;
  assign owed       = {1'b0, cnt_q} + {2'b00, s1_valid_q} - {2'b00, pop};
  assign req_ready  = rst_n & (owed <= 3'd1);
  assign accept     = req_valid & req_ready;

  // RAM side: address and data flow straight through; writes only on an accepted, valid request.
  assign ram_addr   = req_addr[abits+obits-1:obits];
  assign ram_wdata  = req_wdata;
  assign ram_we     = (accept && !misaligned) ? req_we : '0;

  // FIFO head; data is masked while empty so outputs read zero during and after reset.
  assign resp_valid = (cnt_q != 2'd0);
  assign head_err   = fifo_err_q[rd_ptr_q];
  assign resp_rdata = resp_valid ? fifo_data_q[rd_ptr_q] : '0;

  // Next-state for the in-flight stage and the FIFO bookkeeping.
  always_comb begin
    s1_valid_d  = accept;
    s1_read_d   = s1_read_q;
    s1_err_d    = s1_err_q;
    if (accept) begin
      s1_read_d = (req_we == '0);
      s1_err_d  = misaligned;
    end
    fifo_data_d = (s1_read_q && !s1_err_q) ? ram_rdata : '0;
    fifo_err_d  = s1_err_q;
    wr_ptr_d    = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d    = pop  ? ~rd_ptr_q : rd_ptr_q;
    cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // Control state; reset drops anything in flight or buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_read_q  <= 1'b0;
      s1_err_q   <= 1'b0;
      cnt_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_read_q  <= s1_read_d;
      s1_err_q   <= s1_err_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are only observed while the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= fifo_data_d;
      fifo_err_q[wr_ptr_q]  <= fifo_err_d;
    end
  end

endmodule

// File: tb/tb_bram_bus_port.sv
// Scoreboard bench for bram_bus_port: a word-level memory model predicts every response at
// accept time; a monitor checks responses in order as the DUT hands them out.
module tb_bram_bus_port;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [AW-1:0] req_addr;
  logic [3:0]  req_we;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  bram_bus_port #(.abits(8), .dbytes(4), .blen(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Attached block RAM: byte-write, read-first, one cycle read latency.
  logic [31:0] ram_mem [256];
  logic        ram_clear;
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
    ram_rdata <= ram_mem[ram_addr];
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [256];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  int          last_pop_cyc = -10;
  int          run = 0;
  int          max_run = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: requests take effect in acceptance order on a plain word array.
  task automatic model_accept(input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] wd);
    exp_t e;
    logic bad;
    int   w;
    w     = int'(a >> 2);
    bad   = 1'b0;
`ifdef BRAM_BUS_PORT_ALIGN_CHECK_EN
    bad   = (a % 4) != 0;
`endif
    e.cyc = cyc;
    e.err = bad;
    e.data = '0;
    if (!bad) begin
      if (we == 4'h0) begin
        e.data = ref_mem[w];
      end else begin
        for (int b = 0; b < 4; b++)
          if (we[b]) ref_mem[w][b*8 +: 8] = wd[b*8 +: 8];
      end
    end
    q.push_back(e);
  endtask

  // One cycle: called at a falling edge, samples just before the rising edge.
  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [3:0] we,
                       input logic [31:0] wd, input logic rr, output logic acc, output logic rv);
    req_valid  = v;
    req_addr   = a;
    req_we     = we;
    req_wdata  = wd;
    resp_ready = rr;
    #4;
    acc = req_valid && req_ready;
    rv  = resp_valid;
    if (acc) model_accept(a, we, wd);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic a, r;
    repeat (n) drive(1'b0, '0, '0, '0, 1'b1, a, r);
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] wd,
                      input logic rr);
    logic acc, rv;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 40) begin
      drive(1'b1, a, we, wd, rr, acc, rv);
      n++;
    end
    req_valid = 1'b0;
    chk("send_accepted", acc, 1);
  endtask

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n === 1'b1) begin
        if (req_valid && !req_ready) chk("ram_we_without_accept", ram_we, 0);
        if (resp_valid && resp_ready) begin
          if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_resp: got rdata %h err %b, expected no response", resp_rdata, resp_err);
          end else begin
            e = q.pop_front();
            chk("resp_rdata", resp_rdata, e.data);
            chk("resp_err", resp_err, e.err);
            chk("resp_latency_min", (cyc >= e.cyc + 2), 1);
          end
          last_rdata = resp_rdata;
          last_err   = resp_err;
          if (last_pop_cyc == cyc - 1) run++;
          else run = 1;
          if (run > max_run) max_run = run;
          last_pop_cyc = cyc;
        end
      end
    end
  end

  // Outstanding responses (in flight plus buffered) never exceed the FIFO depth.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n === 1'b1) chk("fifo_bound", (q.size() <= 2), 1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a1, a2, a3, rv;
    logic [AW-1:0] ra;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    ram_clear  = 1'b1;
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 10'h040;
    req_we     = 4'hF;
    req_wdata  = 32'h0BADF00D;
    resp_ready = 1'b1;
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_ram_we", ram_we, 0);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ram_clear = 1'b0;
    rst_n     = 1'b1;

    // Full-word write then read, with exact 2-cycle latency.
    send(10'h010, 4'hF, 32'hDEADBEEF, 1'b1);
    idle(3);
    send(10'h010, 4'h0, 32'h0, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1, a1, rv);
    chk("lat_not_early", rv, 0);
    drive(1'b0, '0, '0, '0, 1'b1, a1, rv);
    chk("lat_at_2", rv, 1);
    idle(2);
    chk("rd_deadbeef", last_rdata, 32'hDEADBEEF);
    chk("rd_deadbeef_err", last_err, 0);

`ifdef BRAM_BUS_PORT_ALIGN_CHECK_EN
    // Misaligned write is rejected and leaves memory untouched.
    send(10'h012, 4'hF, 32'hCAFEF00D, 1'b1);
    idle(3);
    chk("misalign_err", last_err, 1);
    chk("misalign_rdata", last_rdata, 0);
    send(10'h010, 4'h0, 32'h0, 1'b1);
    idle(3);
    chk("misalign_kept", last_rdata, 32'hDEADBEEF);
`endif

    // Partial byte write merges into the existing word.
    send(10'h020, 4'hF, 32'h11223344, 1'b1);
    send(10'h020, 4'h1, 32'h000000AA, 1'b1);
    send(10'h020, 4'h0, 32'h0, 1'b1);
    idle(3);
    chk("byte_merge", last_rdata, 32'h112233AA);

    // Sixteen back-to-back reads.
    max_run = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, AW'(i * 4), 4'h0, 32'h0, 1'b1, a1, rv);
      chk("b2b_accept", a1, 1);
    end
    idle(4);
    chk("b2b_consecutive", max_run, 16);

    // Backpressure: two accepted, third blocked with no RAM write.
    drive(1'b1, 10'h010, 4'h0, 32'h0, 1'b0, a1, rv);
    drive(1'b1, 10'h020, 4'h0, 32'h0, 1'b0, a2, rv);
    chk("bp_first", a1, 1);
    chk("bp_second", a2, 1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 10'h030, 4'hF, 32'h5555AAAA, 1'b0, a3, rv);
      chk("bp_third_blocked", a3, 0);
    end
    send(10'h030, 4'hF, 32'h5555AAAA, 1'b1);
    idle(3);
    send(10'h030, 4'h0, 32'h0, 1'b1);
    idle(3);
    chk("bp_third_written", last_rdata, 32'h5555AAAA);

    // Reset with two responses owed.
    send(10'h010, 4'h0, 32'h0, 1'b0);
    send(10'h020, 4'h0, 32'h0, 1'b0);
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_addr  = 10'h044;
    req_we    = 4'hF;
    #1;
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_ram_we", ram_we, 0);
    chk("midrst_resp_rdata", resp_rdata, 0);
    q.delete();
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, '0, '0, '0, 1'b1, a1, rv);
      chk("no_stale_resp", rv, 0);
    end

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      ra = AW'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) ra = ra + AW'($urandom_range(0, 3));
      drive(($urandom_range(0, 3) != 0), ra,
            ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
            $urandom, ($urandom_range(0, 3) != 0), a1, rv);
    end
    idle(8);
    chk("drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
